// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Covers the state encoding, owner ids, default error data and the tie-break rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

  // On a tie, round-robin hands the port to whoever did not own it last.
  function automatic logic pick_owner(
    input logic cpu,
    input logic dma,
    input logic last,
    input logic prio
  );
    logic w;
    if (cpu && dma)
      w = prio ? OWN_CPU : ~last;
    else if (dma)
      w = OWN_DMA;
    else
      w = OWN_CPU;
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: clear/enable counter.
// o_expire is high in the cycle that would be the TIMEOUT-th counted cycle.
module mem_arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;
  logic         w_hit;

  assign w_hit    = (r_cnt == LAST);
  assign o_expire = i_en && w_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_hit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between the CPU and the DMA engine.
// Each access runs IDLE -> ACCESS -> RESP; the winner gets a one-cycle ready pulse.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          PRIO_MODE = 0,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        dma_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  grant,
  output logic        busy
);

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_owner;
  logic        r_last;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_cpu_rdata;
  logic [31:0] r_dma_rdata;

  logic w_start;
  logic w_win;
  logic w_access;
  logic w_resp;
  logic w_ack;
  logic w_expire;
  logic w_tmr_en;

  assign w_access = (r_state == ST_ACCESS);
  assign w_resp   = (r_state == ST_RESP);
  assign w_start  = (r_state == ST_IDLE) && (cpu_req || dma_req);
  assign w_win    = pick_owner(cpu_req, dma_req, r_last,
                               PRIO_MODE != 0);
  assign w_ack    = w_access && mem_ack;
  assign w_tmr_en = w_access && !mem_ack;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_start),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE:
        if (cpu_req || dma_req)
          w_state_nx = ST_ACCESS;
      ST_ACCESS:
        if (mem_ack || w_expire)
          w_state_nx = ST_RESP;
      ST_RESP:
        w_state_nx = ST_IDLE;
      default:
        w_state_nx = ST_IDLE;
    endcase
  end

  // Request fields are captured once so the owner may change them freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= OWN_CPU;
      r_last      <= OWN_DMA;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_start) begin
        r_owner <= w_win;
        r_last  <= w_win;
        r_err   <= 1'b0;
        if (w_win == OWN_DMA) begin
          r_we    <= dma_we;
          r_addr  <= dma_addr;
          r_wdata <= dma_wdata;
        end else begin
          r_we    <= cpu_we;
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
        end
      end
      if (w_ack) begin
        r_err <= 1'b0;
        if (!r_we) begin
          if (r_owner == OWN_DMA)
            r_dma_rdata <= mem_rdata;
          else
            r_cpu_rdata <= mem_rdata;
        end
      end else if (w_expire) begin
        r_err <= 1'b1;
        if (!r_we) begin
          if (r_owner == OWN_DMA)
            r_dma_rdata <= ERR_DATA;
          else
            r_cpu_rdata <= ERR_DATA;
        end
      end
    end
  end

  assign mem_req   = w_access;
  assign mem_we    = w_access && r_we;
  assign mem_addr  = w_access ? r_addr : '0;
  assign mem_wdata = w_access ? r_wdata : '0;

  assign busy  = w_access || w_resp;
  assign grant = !busy ? 2'b00 :
                 (r_owner == OWN_DMA) ? 2'b10 : 2'b01;

  assign cpu_ready = w_resp && (r_owner == OWN_CPU);
  assign dma_ready = w_resp && (r_owner == OWN_DMA);
  assign cpu_err   = cpu_ready && r_err;
  assign dma_err   = dma_ready && r_err;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: stimulus pushes expected completions, monitors pop on ready.
// u0 runs round-robin with a scripted memory, u1 runs CPU-priority with auto-ack.
module tb_mem_bus_arbiter;

  localparam logic [31:0] K = 32'h5A5A0000;

  typedef struct {
    logic [1:0]  who;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;

  logic [31:0] c0_cpu_rdata, c0_dma_rdata, c0_mem_addr, c0_mem_wdata;
  logic        c0_cpu_ready, c0_cpu_err, c0_dma_ready, c0_dma_err;
  logic        c0_mem_req, c0_mem_we, c0_busy;
  logic [1:0]  c0_grant;
  logic [31:0] m0_rdata;
  logic        m0_ack;

  logic [31:0] c1_cpu_rdata, c1_dma_rdata, c1_mem_addr, c1_mem_wdata;
  logic        c1_cpu_ready, c1_cpu_err, c1_dma_ready, c1_dma_err;
  logic        c1_mem_req, c1_mem_we, c1_busy;
  logic [1:0]  c1_grant;

  int          ack_lat = 1;
  int          acc_cnt = 0;
  logic        auto_ack = 1'b0;
  logic        force_ack = 1'b0;
  logic        from_addr = 1'b0;
  logic [31:0] rdata_val = '0;
  logic        mon0_en = 1'b0;
  logic        mon1_en = 1'b0;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  assign m0_ack   = auto_ack | force_ack;
  assign m0_rdata = from_addr ? (c0_mem_addr ^ K) : rdata_val;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.PRIO_MODE(0), .TIMEOUT(16)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(c0_cpu_rdata), .cpu_ready(c0_cpu_ready),
    .cpu_err(c0_cpu_err),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(c0_dma_rdata), .dma_ready(c0_dma_ready),
    .dma_err(c0_dma_err),
    .mem_req(c0_mem_req), .mem_we(c0_mem_we),
    .mem_addr(c0_mem_addr), .mem_wdata(c0_mem_wdata),
    .mem_rdata(m0_rdata), .mem_ack(m0_ack),
    .grant(c0_grant), .busy(c0_busy)
  );

  mem_bus_arbiter #(.PRIO_MODE(1), .TIMEOUT(16)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(c1_cpu_rdata), .cpu_ready(c1_cpu_ready),
    .cpu_err(c1_cpu_err),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(c1_dma_rdata), .dma_ready(c1_dma_ready),
    .dma_err(c1_dma_err),
    .mem_req(c1_mem_req), .mem_we(c1_mem_we),
    .mem_addr(c1_mem_addr), .mem_wdata(c1_mem_wdata),
    .mem_rdata(c1_mem_addr ^ K), .mem_ack(c1_mem_req),
    .grant(c1_grant), .busy(c1_busy)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scripted memory for u0: ack in the ack_lat-th ACCESS cycle, 0 = never.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (c0_mem_req) acc_cnt++;
      else acc_cnt = 0;
      auto_ack = (ack_lat != 0) && (acc_cnt == ack_lat);
    end
  end

  always @(negedge clk) begin
    if (mon0_en && !reset && (c0_cpu_ready || c0_dma_ready)) begin
      if (q0.size() == 0) begin
        check("u0 unexpected ready",
              {30'd0, c0_dma_ready, c0_cpu_ready}, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("u0 ready who",
              {30'd0, c0_dma_ready, c0_cpu_ready}, {30'd0, e.who});
        if (e.who == 2'b10) begin
          check("u0 dma err", {31'd0, c0_dma_err}, {31'd0, e.err});
          check("u0 dma rdata", c0_dma_rdata, e.data);
        end else begin
          check("u0 cpu err", {31'd0, c0_cpu_err}, {31'd0, e.err});
          check("u0 cpu rdata", c0_cpu_rdata, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon1_en && !reset && (c1_cpu_ready || c1_dma_ready)) begin
      if (q1.size() == 0) begin
        check("u1 unexpected ready",
              {30'd0, c1_dma_ready, c1_cpu_ready}, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("u1 ready who",
              {30'd0, c1_dma_ready, c1_cpu_ready}, {30'd0, e.who});
        check("u1 cpu err", {31'd0, c1_cpu_err}, {31'd0, e.err});
        check("u1 cpu rdata", c1_cpu_rdata, e.data);
      end
    end
  end

  task automatic push0(input logic [1:0] who, input logic err,
                       input logic [31:0] data);
    exp_t e;
    e.who = who; e.err = err; e.data = data;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [31:0] data);
    exp_t e;
    e.who = 2'b01; e.err = 1'b0; e.data = data;
    q1.push_back(e);
  endtask

  // One access on u0; owner fields are scrambled mid-access to prove latching.
  task automatic txn(input logic m, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int exp_acc, input string tag);
    int n, acc;
    logic bad, done;
    logic [1:0] g;
    n = 0; acc = 0; bad = 1'b0; done = 1'b0;
    g = m ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    if (m) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      n++;
      if (c0_mem_req) begin
        acc++;
        if (c0_mem_we !== we || c0_mem_addr !== addr ||
            c0_mem_wdata !== wd || c0_grant !== g)
          bad = 1'b1;
        if (m) begin
          dma_addr = 32'hFFFF_0000; dma_wdata = 32'h0;
        end else begin
          cpu_addr = 32'hFFFF_0000; cpu_wdata = 32'h0;
        end
      end
      if ((m ? c0_dma_ready : c0_cpu_ready) === 1'b1) done = 1'b1;
    end
    check({tag, " ready seen"}, {31'd0, done}, 32'd1);
    check({tag, " latency"}, n, exp_acc + 2);
    check({tag, " access cycles"}, acc, exp_acc);
    check({tag, " bus stable"}, {31'd0, bad}, 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic drain(input int which, input string tag);
    int k;
    k = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    check({tag, " drained"}, (which == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    int rdy;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst grant", {30'd0, c0_grant}, 32'd0);
    check("rst busy", {31'd0, c0_busy}, 32'd0);
    check("rst mem_req", {31'd0, c0_mem_req}, 32'd0);
    check("rst mem_addr", c0_mem_addr, 32'd0);
    check("rst ready", {30'd0, c0_dma_ready, c0_cpu_ready}, 32'd0);
    check("rst cpu_rdata", c0_cpu_rdata, 32'd0);
    check("rst dma_rdata", c0_dma_rdata, 32'd0);
    mon0_en = 1'b1;

    ack_lat = 1; rdata_val = 32'h12345678;
    push0(2'b01, 1'b0, 32'h12345678);
    txn(1'b0, 1'b0, 32'h100, 32'h0, 1, "cpu rd");

    ack_lat = 3; rdata_val = 32'h0BADF00D;
    push0(2'b01, 1'b0, 32'h12345678);
    txn(1'b0, 1'b1, 32'h200, 32'hA5A5A5A5, 3, "cpu wr");

    ack_lat = 0;
    push0(2'b10, 1'b1, 32'hDEADBEEF);
    txn(1'b1, 1'b0, 32'h300, 32'h0, 16, "dma timeout");

    ack_lat = 16; rdata_val = 32'hCAFEF00D;
    push0(2'b10, 1'b0, 32'hCAFEF00D);
    txn(1'b1, 1'b0, 32'h304, 32'h0, 16, "dma ack16");
    drain(0, "basic");

    ack_lat = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    check("mid rst busy", {31'd0, c0_busy}, 32'd0);
    check("mid rst grant", {30'd0, c0_grant}, 32'd0);
    check("mid rst mem_req", {31'd0, c0_mem_req}, 32'd0);
    check("mid rst cpu_rdata", c0_cpu_rdata, 32'd0);
    check("mid rst dma_rdata", c0_dma_rdata, 32'd0);
    rdy = 0;
    @(posedge clk); #1 force_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (c0_cpu_ready || c0_dma_ready || c0_busy) rdy++;
    end
    check("late ack ignored", rdy, 0);

    ack_lat = 1; from_addr = 1'b1;
    push0(2'b01, 1'b0, 32'h400 ^ K);
    push0(2'b10, 1'b0, 32'h800 ^ K);
    push0(2'b01, 1'b0, 32'h400 ^ K);
    push0(2'b10, 1'b0, 32'h800 ^ K);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h800;
    drain(0, "rr");
    #1 cpu_req = 1'b0; dma_req = 1'b0;
    repeat (4) @(posedge clk);

    mon0_en = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    mon1_en = 1'b1;
    for (int i = 0; i < 4; i++) push1(32'h400 ^ K);
    @(posedge clk); #1;
    cpu_req = 1'b1; dma_req = 1'b1;
    drain(1, "prio");
    #1 cpu_req = 1'b0; dma_req = 1'b0;
    repeat (4) @(posedge clk);
    check("q0 empty", q0.size(), 0);
    check("q1 empty", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
